// File: rtl/accel_pkg.sv
// Shared constants, state encoding and frame helpers for the accelerometer SPI reader.
package accel_pkg;

  localparam logic [7:0]  ADXL_CMD_READ  = 8'h0B;
  localparam logic [7:0]  ADXL_REG_XDATA = 8'h08;
  localparam int unsigned FRAME_BITS     = 40;
  localparam int unsigned RD_BYTES       = 3;
  localparam int unsigned BITCNT_W       = 6;

  typedef enum logic [2:0] {
    IDLE,
    CSS,
    SHIFT,
    CSH,
    DONE
  } state_t;

  // Command and address go out first; the read bytes are clocked with mosi low.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] cmd,
                                                        input logic [7:0] addr);
    return {cmd, addr, {(8*RD_BYTES){1'b0}}};
  endfunction

  // idx 0 is the first data byte after the command/address echo.
  function automatic logic [7:0] rx_byte(input logic [FRAME_BITS-1:0] frame,
                                         input int unsigned idx);
    return frame[8*(RD_BYTES-1-idx) +: 8];
  endfunction

endpackage

// File: rtl/spi_shifter.sv
// SPI mode-0 shift engine: sclk toggles once per tick, samples miso on rising
// edges and advances mosi on falling edges over one fixed-length frame.
module spi_shifter
  import accel_pkg::*;
(
  input  logic                  ck,
  input  logic                  clr_n,
  input  logic                  tick,
  input  logic                  load,
  input  logic                  miso,
  input  logic [FRAME_BITS-1:0] tx_frame,
  output logic                  sclk,
  output logic                  mosi,
  output logic [FRAME_BITS-1:0] rx_frame,
  output logic                  last
);

  logic [FRAME_BITS-1:0] tx_sr;
  logic [BITCNT_W-1:0]   bitcnt;

  always_ff @(posedge ck or negedge clr_n) begin
    if (!clr_n) begin
      tx_sr    <= '0;
      rx_frame <= '0;
      bitcnt   <= '0;
      sclk     <= 1'b0;
    end else if (load) begin
      tx_sr    <= tx_frame;
      rx_frame <= '0;
      bitcnt   <= '0;
      sclk     <= 1'b0;
    end else if (tick) begin
      if (!sclk) begin
        sclk     <= 1'b1;
        rx_frame <= {rx_frame[FRAME_BITS-2:0], miso};
      end else begin
        sclk   <= 1'b0;
        tx_sr  <= {tx_sr[FRAME_BITS-2:0], 1'b0};
        bitcnt <= bitcnt + 1'b1;
      end
    end
  end

  assign mosi = tx_sr[FRAME_BITS-1];

  // High on the tick that produces the final falling edge of the frame.
  assign last = tick & sclk & (bitcnt == BITCNT_W'(FRAME_BITS - 1));

endmodule

// File: rtl/accel_spi_reader.sv
// Burst-reads XDATA/YDATA/ZDATA over SPI mode 0, paced by the divider tick;
// x/y/z update together with a one-cycle done pulse.
module accel_spi_reader
  import accel_pkg::*;
#(
  parameter logic [7:0]  CMD_READ   = ADXL_CMD_READ,
  parameter logic [7:0]  START_ADDR = ADXL_REG_XDATA,
  parameter int unsigned CSS_TICKS  = 2,
  parameter int unsigned CSH_TICKS  = 2
) (
  input  logic       ck,
  input  logic       clr_n,
  input  logic       tick,
  input  logic       start,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic       cs_n,
  output logic       busy,
  output logic       done,
  output logic [7:0] x,
  output logic [7:0] y,
  output logic [7:0] z
);

  localparam int unsigned TCNT_MAX = (CSS_TICKS > CSH_TICKS) ? CSS_TICKS : CSH_TICKS;
  localparam int unsigned TCNT_W   = $clog2(TCNT_MAX + 1);

  state_t                state;
  logic [TCNT_W-1:0]     tcnt;
  logic                  sh_tick;
  logic                  sh_load;
  logic                  sh_last;
  logic [FRAME_BITS-1:0] rx_frame;

  // busy is still high during the first IDLE cycle, so a start held through
  // DONE is only taken once busy has dropped.
  assign sh_load = (state == IDLE) && start && !busy;
  assign sh_tick = tick && (state == SHIFT);

  spi_shifter u_shifter (
    .ck       (ck),
    .clr_n    (clr_n),
    .tick     (sh_tick),
    .load     (sh_load),
    .miso     (miso),
    .tx_frame (build_frame(CMD_READ, START_ADDR)),
    .sclk     (sclk),
    .mosi     (mosi),
    .rx_frame (rx_frame),
    .last     (sh_last)
  );

  always_ff @(posedge ck or negedge clr_n) begin
    if (!clr_n) begin
      state <= IDLE;
      tcnt  <= '0;
      cs_n  <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
      x     <= '0;
      y     <= '0;
      z     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (sh_load) begin
            state <= CSS;
            tcnt  <= '0;
            cs_n  <= 1'b0;
            busy  <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        CSS: begin
          if (tick) begin
            if (tcnt == TCNT_W'(CSS_TICKS - 1)) begin
              state <= SHIFT;
              tcnt  <= '0;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        end
        SHIFT: begin
          if (sh_last) begin
            state <= CSH;
            tcnt  <= '0;
          end
        end
        CSH: begin
          if (tick) begin
            if (tcnt == TCNT_W'(CSH_TICKS - 1)) begin
              state <= DONE;
              tcnt  <= '0;
              cs_n  <= 1'b1;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        end
        DONE: begin
          x     <= rx_byte(rx_frame, 0);
          y     <= rx_byte(rx_frame, 1);
          z     <= rx_byte(rx_frame, 2);
          done  <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          tcnt  <= '0;
          cs_n  <= 1'b1;
        end
      endcase
    end
  end

endmodule
